// File: rtl/strided_split_pkg.sv
// Shared types and constants for the strided split stage.
package strided_split_pkg;

    localparam int unsigned N_LANES = 16;
    localparam int unsigned SEL_W   = 4;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DELAY  = 2'd1;
    localparam state_t ST_ACTIVE = 2'd2;

    // One-hot decode of a lane index
    function automatic logic [N_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] s);
        logic [N_LANES-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/strided_split_ctrl.sv
// Sequencing for strided_split: start delay, per-lane sample count and lane select.
// Optional STRIDED_SPLIT_VALID_EN adds a one-cycle per-lane completion pulse.
module strided_split_ctrl
    import strided_split_pkg::*;
#(
    parameter int unsigned DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               running,
    input  logic [DELAY_W-1:0] stride,
    input  logic [DELAY_W-1:0] delay0,
    output logic               wr_en,
    output logic [SEL_W-1:0]   sel
`ifdef STRIDED_SPLIT_VALID_EN
    ,
    output logic [N_LANES-1:0] valid
`endif
);

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] dcnt_q, dcnt_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DELAY_W-1:0] stride_q, stride_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
`ifdef STRIDED_SPLIT_VALID_EN
    logic [N_LANES-1:0] valid_q, valid_d;
`endif

    // Next-state logic: run restarts from any state, running=0 freezes everything
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        cnt_d    = cnt_q;
        stride_d = stride_q;
        sel_d    = sel_q;
        wr_en    = 1'b0;
`ifdef STRIDED_SPLIT_VALID_EN
        valid_d  = '0;
`endif
        if (run) begin
            stride_d = stride;
            dcnt_d   = delay0;
            cnt_d    = '0;
            sel_d    = '0;
            state_d  = (delay0 != '0) ? ST_DELAY : ST_ACTIVE;
        end else if (running) begin
            case (state_q)
                ST_DELAY: begin
                    dcnt_d = dcnt_q - DELAY_W'(1);
                    if (dcnt_q == DELAY_W'(1)) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    wr_en = 1'b1;
                    if (cnt_q == stride_q) begin
                        cnt_d = '0;
                        sel_d = sel_q + SEL_W'(1);
`ifdef STRIDED_SPLIT_VALID_EN
                        valid_d = lane_onehot(sel_q);
`endif
                    end else begin
                        cnt_d = cnt_q + DELAY_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dcnt_q   <= '0;
            cnt_q    <= '0;
            stride_q <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            cnt_q    <= cnt_d;
            stride_q <= stride_d;
            sel_q    <= sel_d;
        end
    end

`ifdef STRIDED_SPLIT_VALID_EN
    // Completion pulse register; lasts one cycle, cleared by run
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
`endif

    assign sel = sel_q;

endmodule

// File: rtl/strided_split.sv
// Distributes one input stream over 16 registered lanes, stride+1 samples per lane.
// Optional STRIDED_SPLIT_VALID_EN adds the per-lane valid pulse output.
module strided_split
    import strided_split_pkg::*;
#(
    parameter int unsigned DELAY_W = 7,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               running,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DELAY_W-1:0] stride,
    input  logic [DELAY_W-1:0] delay0,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    output logic [DATA_W-1:0]  out2,
    output logic [DATA_W-1:0]  out3,
    output logic [DATA_W-1:0]  out4,
    output logic [DATA_W-1:0]  out5,
    output logic [DATA_W-1:0]  out6,
    output logic [DATA_W-1:0]  out7,
    output logic [DATA_W-1:0]  out8,
    output logic [DATA_W-1:0]  out9,
    output logic [DATA_W-1:0]  out10,
    output logic [DATA_W-1:0]  out11,
    output logic [DATA_W-1:0]  out12,
    output logic [DATA_W-1:0]  out13,
    output logic [DATA_W-1:0]  out14,
    output logic [DATA_W-1:0]  out15
`ifdef STRIDED_SPLIT_VALID_EN
    ,
    output logic [N_LANES-1:0] valid
`endif
);

    logic               wr_en;
    logic [SEL_W-1:0]   sel;
    logic [N_LANES-1:0] lane_we;
    logic [DATA_W-1:0]  lane_q [N_LANES];

    strided_split_ctrl #(
        .DELAY_W (DELAY_W)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .running (running),
        .stride  (stride),
        .delay0  (delay0),
        .wr_en   (wr_en),
        .sel     (sel)
`ifdef STRIDED_SPLIT_VALID_EN
        ,
        .valid   (valid)
`endif
    );

    // Write decode: at most one lane enabled per cycle
    always_comb begin
        lane_we = wr_en ? lane_onehot(sel) : '0;
    end

    // Lane registers hold their value until the selector returns to them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                if (lane_we[k]) begin
                    lane_q[k] <= in0;
                end
            end
        end
    end

    assign out0  = lane_q[0];
    assign out1  = lane_q[1];
    assign out2  = lane_q[2];
    assign out3  = lane_q[3];
    assign out4  = lane_q[4];
    assign out5  = lane_q[5];
    assign out6  = lane_q[6];
    assign out7  = lane_q[7];
    assign out8  = lane_q[8];
    assign out9  = lane_q[9];
    assign out10 = lane_q[10];
    assign out11 = lane_q[11];
    assign out12 = lane_q[12];
    assign out13 = lane_q[13];
    assign out14 = lane_q[14];
    assign out15 = lane_q[15];

endmodule
